pico_bram_arbiter: RTL and testbench
====================================

// Module: pico_bram_arbiter
// PURPOSE
//  Shares one single-port BRAM port between two PicoRV32 native-memory requesters (M0, M1),
//  e.g. core instruction/data ports or core plus host debug master. Sequences each access
//  (issue, wait for BRAM read latency, respond) and grants requesters round-robin or fixed-priority.
//  Sits between the requesters' mem_* signals and a Xilinx BRAM controller-style port.
// PARAMETERS
//  C_ADDR_WIDTH    32  width of BRAM_ADDR; low C_ADDR_WIDTH bits of Mx_MEM_ADDR passed through
//  C_READ_LATENCY  1   cycles from BRAM_EN sample edge to valid BRAM_DOUT; legal range 1..15
//  C_FIXED_PRIO    0   0 = round-robin; 1 = M0 always wins when both request
// PORTS
//  CLK           in   1             clock; also driven out on BRAM_CLK
//  RSTN          in   1             reset, synchronous, active-low
//  M0_MEM_VALID  in   1             M0 request; held until M0_MEM_READY
//  M0_MEM_ADDR   in   32            M0 byte address
//  M0_MEM_WDATA  in   32            M0 write data
//  M0_MEM_WSTRB  in   4             M0 byte write strobes; 0 = read
//  M0_MEM_READY  out  1             one-cycle completion pulse to M0
//  M0_MEM_RDATA  out  32            read data to M0, valid when M0_MEM_READY
//  M1_*          --   --            identical set of six ports for M1
//  BRAM_ADDR     out  C_ADDR_WIDTH  address of granted requester
//  BRAM_CLK      out  1             = CLK
//  BRAM_DIN      out  32            WDATA of granted requester
//  BRAM_DOUT     in   32            BRAM read data
//  BRAM_EN       out  1             port enable
//  BRAM_WE       out  4             byte write enables
//  BRAM_RST      out  1             = ~RSTN
// BEHAVIOUR
//  FSM states: IDLE, ISSUE, WAIT, RESP. Registers: state, grant (0=M0, 1=M1), last, wait counter.
//  IDLE: if any Mx_MEM_VALID, latch grant per arbitration and go to ISSUE; otherwise stay.
//  Arbitration: only one valid -> that one wins. Both valid -> C_FIXED_PRIO=1 picks M0;
//   otherwise picks the requester != last. last <= grant on entry to ISSUE.
//  ISSUE (exactly 1 cycle): BRAM_EN=1, BRAM_WE=WSTRB of granted requester.
//   Next state is RESP if C_READ_LATENCY==1; else WAIT with counter=C_READ_LATENCY-2.
//  WAIT: BRAM_EN=0, BRAM_WE=0. Counter decrements each cycle; go to RESP when it is 0.
//  RESP (exactly 1 cycle): granted Mx_MEM_READY=1. Next state is always IDLE.
//  Timing: valid first sampled in IDLE at cycle t -> ready in cycle t+C_READ_LATENCY+1.
//   Each access occupies C_READ_LATENCY+2 cycles including IDLE. Writes use identical timing.
//  BRAM_ADDR/BRAM_DIN are combinationally muxed from the granted requester in every state.
//  Mx_MEM_RDATA = BRAM_DOUT for both requesters (broadcast); only the granted requester sees READY.
//  Non-granted requester: READY=0; its request stays pending and is served next.
//  Granted requester dropping VALID before READY is a protocol violation; the access still
//   completes and READY still pulses.
//  Reset (RSTN=0, any state incl. mid-access): next edge -> IDLE, grant=0, last=1 (M0 first),
//   counter=0. Outputs in reset: BRAM_EN=0, BRAM_WE=0, M0/M1_MEM_READY=0, BRAM_RST=1.
//  BRAM_EN/BRAM_WE are never asserted outside ISSUE; READY is never asserted outside RESP.
// TESTING
//  T1 L=1: M0 read addr 0x10 (BRAM holds 0xDEADBEEF), valid at cycle 0 -> EN=1 only in cycle 1,
//   M0_MEM_READY=1 only in cycle 2, M0_MEM_RDATA=0xDEADBEEF.
//  T2 L=3: M1 write 0x20, data 0x12345678, WSTRB=0x3 -> WE=0x3 in cycle 1 only, READY in cycle 4;
//   a later read of 0x20 returns 0x????5678 (upper bytes unchanged).
//  T3 round-robin: M0 and M1 valid continuously from reset for 8 accesses -> grants alternate
//   M0,M1,M0,...; each requester gets 4 READY pulses, never on the same cycle.
//  T4 C_FIXED_PRIO=1: both valid continuously -> M0 granted every access; M1 is served only
//   after M0 drops VALID.
//  T5 reset mid-access: L=3, RSTN=0 during WAIT -> no READY pulse; FSM in IDLE; EN=0 next cycle;
//   a new request after reset completes normally.
//  T6 random: both requesters issue random reads/writes against a reference memory model
//   -> all read data matches; at most one READY per cycle; EN asserted once per READY.

Source files
------------

// File: rtl/pico_bram_arbiter_if.sv
// pico_bram_arbiter_if: one PicoRV32 native-memory requester bundle.
// The requester drives the master side; the arbiter consumes it on the slave side.
interface pico_bram_arbiter_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/pico_bram_arbiter.sv
// pico_bram_arbiter: shares one single-port BRAM between two PicoRV32 native
// memory requesters. Each access is sequenced IDLE -> ISSUE -> (WAIT) -> RESP,
// so exactly one access is in flight and it occupies C_READ_LATENCY+2 cycles.
// Both masters see BRAM_DOUT on their rdata; only the granted one gets READY.
module pico_bram_arbiter #(
   parameter int C_ADDR_WIDTH   = 32,
   parameter int C_READ_LATENCY = 1,
   parameter int C_FIXED_PRIO   = 0
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   pico_bram_arbiter_if.slave      m0_if,
   pico_bram_arbiter_if.slave      m1_if,
   output logic [C_ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic                    BRAM_CLK,
   output logic [31:0]             BRAM_DIN,
   input  logic [31:0]             BRAM_DOUT,
   output logic                    BRAM_EN,
   output logic [3:0]              BRAM_WE,
   output logic                    BRAM_RST
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   // WAIT is entered with the number of extra cycles still owed to the BRAM
   // pipeline; the ISSUE cycle and the transition into RESP cover the other two.
   localparam logic [3:0] CNT_INIT = (C_READ_LATENCY > 1) ? 4'(C_READ_LATENCY - 2) : 4'd0;

   logic [1:0] state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_q,  last_d;
   logic [3:0] cnt_q,   cnt_d;
   logic       pick_s;

   // Arbitration choice for a request seen in IDLE.
   always_comb begin
      if (m0_if.mem_valid && m1_if.mem_valid) begin
         if (C_FIXED_PRIO != 0) begin
            pick_s = 1'b0;
         end else begin
            pick_s = ~last_q;
         end
      end else if (m1_if.mem_valid) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
   end

   // Access sequencer next-state logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (m0_if.mem_valid || m1_if.mem_valid) begin
               grant_d = pick_s;
               last_d  = pick_s;
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (C_READ_LATENCY == 1) begin
               state_d = S_RESP;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer registers; reset makes M0 the first round-robin winner.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobes are decoded from the state register and held off while in reset.
   assign BRAM_EN   = RSTN && (state_q == S_ISSUE);
   assign BRAM_WE   = BRAM_EN ? (grant_q ? m1_if.mem_wstrb : m0_if.mem_wstrb) : 4'h0;
   assign BRAM_ADDR = grant_q ? m1_if.mem_addr[C_ADDR_WIDTH-1:0] : m0_if.mem_addr[C_ADDR_WIDTH-1:0];
   assign BRAM_DIN  = grant_q ? m1_if.mem_wdata : m0_if.mem_wdata;
   assign BRAM_CLK  = CLK;
   assign BRAM_RST  = ~RSTN;

   assign m0_if.mem_ready = RSTN && (state_q == S_RESP) && !grant_q;
   assign m1_if.mem_ready = RSTN && (state_q == S_RESP) &&  grant_q;
   assign m0_if.mem_rdata = BRAM_DOUT;
   assign m1_if.mem_rdata = BRAM_DOUT;

endmodule

// File: tb/tb_pico_bram_arbiter.sv
// tb_pico_bram_arbiter: two arbiter instances (0: latency 1 round-robin,
// 1: latency 3 fixed priority), each behind a behavioural BRAM. A slot-level
// reference model predicts grants, strobes, READY timing and read data.
module tb_pico_bram_arbiter;

   logic CLK = 1'b0;
   logic RSTN;

   always #5 CLK = ~CLK;

   // Requester index r = 2*dut + master.
   logic        valid [4];
   logic [31:0] addr  [4];
   logic [31:0] wdata [4];
   logic [3:0]  wstrb [4];
   logic        ready [4];
   logic [31:0] rdata [4];

   logic [31:0] b_addr [2];
   logic        b_clk  [2];
   logic [31:0] b_din  [2];
   logic [31:0] b_dout [2];
   logic        b_en   [2];
   logic [3:0]  b_we   [2];
   logic        b_rst  [2];

   pico_bram_arbiter_if m0_if [2] ();
   pico_bram_arbiter_if m1_if [2] ();

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) begin
         return 32'hDEADBEEF;
      end
      return 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   genvar g;
   for (g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [31:0] mem  [256];
      logic [31:0] pipe [LAT];

      assign m0_if[g].mem_valid = valid[2*g];
      assign m0_if[g].mem_addr  = addr[2*g];
      assign m0_if[g].mem_wdata = wdata[2*g];
      assign m0_if[g].mem_wstrb = wstrb[2*g];
      assign ready[2*g]         = m0_if[g].mem_ready;
      assign rdata[2*g]         = m0_if[g].mem_rdata;
      assign m1_if[g].mem_valid = valid[2*g+1];
      assign m1_if[g].mem_addr  = addr[2*g+1];
      assign m1_if[g].mem_wdata = wdata[2*g+1];
      assign m1_if[g].mem_wstrb = wstrb[2*g+1];
      assign ready[2*g+1]       = m1_if[g].mem_ready;
      assign rdata[2*g+1]       = m1_if[g].mem_rdata;

      pico_bram_arbiter #(
         .C_ADDR_WIDTH   (32),
         .C_READ_LATENCY (LAT),
         .C_FIXED_PRIO   (g)
      ) u_dut (
         .CLK       (CLK),
         .RSTN      (RSTN),
         .m0_if     (m0_if[g]),
         .m1_if     (m1_if[g]),
         .BRAM_ADDR (b_addr[g]),
         .BRAM_CLK  (b_clk[g]),
         .BRAM_DIN  (b_din[g]),
         .BRAM_DOUT (b_dout[g]),
         .BRAM_EN   (b_en[g]),
         .BRAM_WE   (b_we[g]),
         .BRAM_RST  (b_rst[g])
      );

      initial begin
         for (int i = 0; i < 256; i++) begin
            mem[i] = init_word(i);
         end
      end

      // Behavioural BRAM: read-first, dout valid LAT cycles after the enable edge.
      always @(posedge CLK) begin
         if (b_en[g]) begin
            for (int b = 0; b < 4; b++) begin
               if (b_we[g][b]) begin
                  mem[b_addr[g][9:2]][8*b +: 8] <= b_din[g][8*b +: 8];
               end
            end
            pipe[0] <= mem[b_addr[g][9:2]];
         end
         for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end

      assign b_dout[g] = pipe[LAT-1];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=0x%08h exp=0x%08h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   // Reference model state: one access slot per DUT.
   int          free_at  [2];
   int          exp_en   [2];
   int          exp_rdy  [2];
   int          win      [2];
   int          last_m   [2];
   bit          acc_live [2];
   logic [31:0] acc_addr [2];
   logic [31:0] acc_wdat [2];
   logic [3:0]  acc_wstb [2];
   logic [31:0] ref_mem  [2][256];

   bit          got_rdy  [4];
   int          served   [4];
   int          rdy_cyc  [4];
   logic [31:0] rdy_data [4];
   int          en_cnt   [2];
   int          rdy_cnt  [2];
   int          dual_rdy = 0;
   bit          rec_seq  = 1'b0;
   int          gseq [$];

   task automatic model_cycle(input int k);
      int         lat;
      int         i0;
      int         i1;
      int         w;
      logic [7:0] wd;
      logic       e_en;
      logic [3:0] e_we;
      logic       er0;
      logic       er1;
      lat = lat_of(k);
      i0  = 2 * k;
      i1  = 2 * k + 1;
      check_eq($sformatf("d%0d_bram_clk", k), 32'(b_clk[k]), 32'(CLK));
      if (!RSTN) begin
         check_eq($sformatf("d%0d_rst_en", k),   32'(b_en[k]),   32'd0);
         check_eq($sformatf("d%0d_rst_we", k),   32'(b_we[k]),   32'd0);
         check_eq($sformatf("d%0d_rst_rdy0", k), 32'(ready[i0]), 32'd0);
         check_eq($sformatf("d%0d_rst_rdy1", k), 32'(ready[i1]), 32'd0);
         check_eq($sformatf("d%0d_rst_brst", k), 32'(b_rst[k]),  32'd1);
         acc_live[k] = 1'b0;
         last_m[k]   = 1;
         free_at[k]  = cyc + 1;
      end else begin
         e_en = acc_live[k] && (cyc == exp_en[k]);
         e_we = e_en ? acc_wstb[k] : 4'h0;
         er0  = acc_live[k] && (cyc == exp_rdy[k]) && (win[k] == 0);
         er1  = acc_live[k] && (cyc == exp_rdy[k]) && (win[k] == 1);
         check_eq($sformatf("d%0d_en", k),   32'(b_en[k]),   32'(e_en));
         check_eq($sformatf("d%0d_we", k),   32'(b_we[k]),   32'(e_we));
         check_eq($sformatf("d%0d_rdy0", k), 32'(ready[i0]), 32'(er0));
         check_eq($sformatf("d%0d_rdy1", k), 32'(ready[i1]), 32'(er1));
         check_eq($sformatf("d%0d_brst", k), 32'(b_rst[k]),  32'd0);
         if (e_en) begin
            check_eq($sformatf("d%0d_addr", k), b_addr[k], acc_addr[k]);
            if (acc_wstb[k] != 4'h0) begin
               check_eq($sformatf("d%0d_din", k), b_din[k], acc_wdat[k]);
            end
         end
         if (er0 || er1) begin
            wd = acc_addr[k][9:2];
            if (acc_wstb[k] == 4'h0) begin
               check_eq($sformatf("d%0d_rdata", k), rdata[2*k+win[k]], ref_mem[k][wd]);
            end else begin
               for (int b = 0; b < 4; b++) begin
                  if (acc_wstb[k][b]) begin
                     ref_mem[k][wd][8*b +: 8] = acc_wdat[k][8*b +: 8];
                  end
               end
            end
            acc_live[k] = 1'b0;
         end
         if (cyc == free_at[k]) begin
            if (valid[i0] || valid[i1]) begin
               if (valid[i0] && valid[i1]) begin
                  w = (k == 1) ? 0 : 1 - last_m[k];
               end else begin
                  w = valid[i1] ? 1 : 0;
               end
               win[k]      = w;
               last_m[k]   = w;
               acc_addr[k] = addr[2*k+w];
               acc_wdat[k] = wdata[2*k+w];
               acc_wstb[k] = wstrb[2*k+w];
               exp_en[k]   = cyc + 1;
               exp_rdy[k]  = cyc + lat + 1;
               free_at[k]  = cyc + lat + 2;
               acc_live[k] = 1'b1;
            end else begin
               free_at[k] = cyc + 1;
            end
         end
      end
   endtask

   // One clock: check at the falling edge, then step requesters after the rising edge.
   task automatic tick();
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         model_cycle(k);
         if (b_en[k]) begin
            en_cnt[k]++;
         end
         if (ready[2*k] && ready[2*k+1]) begin
            dual_rdy++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (ready[i]) begin
            got_rdy[i]  = 1'b1;
            served[i]++;
            rdy_cnt[i/2]++;
            rdy_cyc[i]  = cyc;
            rdy_data[i] = rdata[i];
         end
      end
      if (rec_seq) begin
         if (ready[0]) gseq.push_back(0);
         if (ready[1]) gseq.push_back(1);
      end
      @(posedge CLK);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (got_rdy[i]) begin
            got_rdy[i] = 1'b0;
            valid[i]   = 1'b0;
         end
      end
   endtask

   task automatic req(input int r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      valid[r] = 1'b1;
      addr[r]  = a;
      wdata[r] = d;
      wstrb[r] = s;
   endtask

   task automatic wait_done(input int r, input int budget, input string tag);
      for (int n = 0; n < budget && valid[r]; n++) begin
         tick();
      end
      check_eq({tag, "_done"}, 32'(valid[r]), 32'd0);
   endtask

   task automatic do_reset();
      RSTN = 1'b0;
      tick();
      RSTN = 1'b1;
   endtask

   int          t0;
   int          s0;
   int          s1;
   int          s2;
   int          s3;
   logic [31:0] iw;
   logic [3:0]  rs;

   initial begin
      for (int i = 0; i < 4; i++) begin
         valid[i] = 1'b0;
         addr[i]  = 32'd0;
         wdata[i] = 32'd0;
         wstrb[i] = 4'h0;
         got_rdy[i] = 1'b0;
         served[i]  = 0;
      end
      for (int k = 0; k < 2; k++) begin
         acc_live[k] = 1'b0;
         free_at[k]  = 0;
         last_m[k]   = 1;
         en_cnt[k]   = 0;
         rdy_cnt[k]  = 0;
         for (int i = 0; i < 256; i++) begin
            ref_mem[k][i] = init_word(i);
         end
      end
      RSTN = 1'b0;
      @(posedge CLK);
      #1;
      tick();
      tick();
      RSTN = 1'b1;

      // T1 (dut0, L=1) read 0x10 and T2 (dut1, L=3) M1 half-word write to 0x20.
      t0 = cyc;
      s0 = served[0];
      req(0, 32'h10, 32'h0, 4'h0);
      req(3, 32'h20, 32'h12345678, 4'h3);
      wait_done(0, 20, "t1");
      wait_done(3, 20, "t2w");
      check_eq("t1_ready_cycle", 32'(rdy_cyc[0] - t0), 32'd2);
      check_eq("t1_rdata", rdy_data[0], 32'hDEADBEEF);
      check_eq("t2_ready_cycle", 32'(rdy_cyc[3] - t0), 32'd4);
      for (int n = 0; n < 4; n++) tick();
      check_eq("t1_one_pulse", 32'(served[0] - s0), 32'd1);
      req(3, 32'h20, 32'h0, 4'h0);
      wait_done(3, 20, "t2r");
      iw = init_word(8);
      check_eq("t2_readback", rdy_data[3], {iw[31:16], 16'h5678});

      // T3 (dut0) round-robin from reset with both masters always requesting.
      do_reset();
      s0 = served[0];
      s1 = served[1];
      rec_seq = 1'b1;
      for (int n = 0; n < 200 && ((served[0] - s0) < 4 || (served[1] - s1) < 4); n++) begin
         if (!valid[0] && (served[0] - s0) < 4) req(0, 32'($urandom_range(0, 63)) << 2, 32'h0, 4'h0);
         if (!valid[1] && (served[1] - s1) < 4) req(1, 32'($urandom_range(0, 63)) << 2, 32'h0, 4'h0);
         tick();
      end
      rec_seq = 1'b0;
      check_eq("t3_m0_count", 32'(served[0] - s0), 32'd4);
      check_eq("t3_m1_count", 32'(served[1] - s1), 32'd4);
      check_eq("t3_seq_len", 32'(gseq.size()), 32'd8);
      for (int i = 0; i < gseq.size(); i++) begin
         check_eq($sformatf("t3_grant%0d", i), 32'(gseq[i]), 32'(i % 2));
      end

      // T4 (dut1) fixed priority: M1 starves until M0 stops requesting.
      s2 = served[2];
      s3 = served[3];
      req(3, 32'h80, 32'h0, 4'h0);
      for (int n = 0; n < 200 && (served[2] - s2) < 5; n++) begin
         if (!valid[2]) req(2, 32'($urandom_range(0, 63)) << 2, 32'h0, 4'h0);
         tick();
      end
      check_eq("t4_m0_served", 32'(served[2] - s2), 32'd5);
      check_eq("t4_m1_starved", 32'(served[3] - s3), 32'd0);
      wait_done(3, 20, "t4_m1");
      check_eq("t4_m1_served", 32'(served[3] - s3), 32'd1);

      // T5 (dut1, L=3) reset during WAIT cancels the access.
      s2 = served[2];
      req(2, 32'h40, 32'h0, 4'h0);
      tick();
      tick();
      RSTN = 1'b0;
      valid[2] = 1'b0;
      tick();
      RSTN = 1'b1;
      for (int n = 0; n < 6; n++) tick();
      check_eq("t5_no_ready", 32'(served[2] - s2), 32'd0);
      t0 = cyc;
      req(2, 32'h40, 32'h0, 4'h0);
      wait_done(2, 20, "t5_after");
      check_eq("t5_ready_cycle", 32'(rdy_cyc[2] - t0), 32'd4);
      check_eq("t5_rdata", rdy_data[2], ref_mem[1][16]);

      // T6 random reads/writes on all four requesters.
      for (int k = 0; k < 2; k++) begin
         en_cnt[k]  = 0;
         rdy_cnt[k] = 0;
      end
      dual_rdy = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int r = 0; r < 4; r++) begin
            if (!valid[r] && $urandom_range(0, 2) != 0) begin
               rs = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
               req(r, 32'($urandom_range(0, 31)) << 2, $urandom, rs);
            end
         end
         tick();
      end
      for (int n = 0; n < 60; n++) tick();
      for (int r = 0; r < 4; r++) begin
         check_eq($sformatf("t6_drain%0d", r), 32'(valid[r]), 32'd0);
      end
      check_eq("t6_en_vs_rdy0", 32'(en_cnt[0]), 32'(rdy_cnt[0]));
      check_eq("t6_en_vs_rdy1", 32'(en_cnt[1]), 32'(rdy_cnt[1]));
      check_eq("t6_dual_ready", 32'(dual_rdy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
